mem_bus_ctrl: RTL and testbench

- Parametrised load/store bus controller between the CPU execute stage and N memory-mapped slaves: data memory, timer and UART by default, extensible to more.
- Replaces the purely combinational DM/timer/UART strobe decode with a registered transaction FSM.
- Adds a per-slave ready handshake, wait states, pipeline stall, bus timeout and bus-error reporting.
- Registers the request, decodes the target slave, holds strobes until that slave answers, then returns the read data to the write-back mux.

---
 rtl/mem_bus_ctrl_if.sv | 32 +++
 rtl/mem_bus_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_ctrl_if.sv
// Bundle of CPU-side load/store request/response and slave-side strobe/ready signals.
// The master modport is the controller's view; the slave modport is the CPU plus slaves.
interface mem_bus_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int N_SLV  = 3
);
    logic                    cpu_rd;
    logic                    cpu_wr;
    logic [ADDR_W-1:0]       cpu_addr;
    logic [DATA_W-1:0]       cpu_wdata;
    logic [DATA_W-1:0]       cpu_rdata;
    logic                    cpu_stall;
    logic                    cpu_err;
    logic [N_SLV-1:0]        slv_sel;
    logic                    slv_rd;
    logic                    slv_wr;
    logic [ADDR_W-1:0]       slv_addr;
    logic [DATA_W-1:0]       slv_wdata;
    logic [N_SLV*DATA_W-1:0] slv_rdata;
    logic [N_SLV-1:0]        slv_ready;

    modport master (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, slv_rdata, slv_ready,
        output cpu_rdata, cpu_stall, cpu_err, slv_sel, slv_rd, slv_wr, slv_addr, slv_wdata
    );

    modport slave (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, slv_rdata, slv_ready,
        input  cpu_rdata, cpu_stall, cpu_err, slv_sel, slv_rd, slv_wr, slv_addr, slv_wdata
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Registered load/store bus controller: latches a CPU request, decodes the target slave,
// holds strobes until that slave is ready (or times out) and returns read data.
module mem_bus_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int N_SLV    = 3,
    parameter int PERI_BIT = 30,
    parameter logic [8*((N_SLV > 2) ? (N_SLV-2) : 1)-1:0] SLV_BOUND = 8'h15,
    parameter int TIMEOUT  = 15,
    parameter logic [DATA_W-1:0] ERR_DATA = '0
) (
    input  logic          clk,
    input  logic          reset,
    mem_bus_ctrl_if.master bus
);
    localparam int NB    = (N_SLV > 2) ? (N_SLV - 2) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] T_MAX = CNT_W'(TIMEOUT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [N_SLV-1:0]  sel_reg, sel_next;
    logic              rd_reg, rd_next;
    logic              wr_reg, wr_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;

    logic [NB-1:0]     below;
    int                dec_idx;
    logic [N_SLV-1:0]  dec_sel;
    logic              ready_hit;
    logic [DATA_W-1:0] sel_rdata;

    // below[k] is set when the low address byte falls under boundary k
    genvar gi;
    generate
        if (N_SLV > 2) begin : g_bounds
            for (gi = 0; gi < N_SLV - 2; gi++) begin : g_cmp
                assign below[gi] = (bus.cpu_addr[7:0] < SLV_BOUND[gi*8 +: 8]);
            end
        end else begin : g_no_bounds
            assign below = '0;
        end
    endgenerate

    // Lowest boundary that the address sits under wins; nothing below means the last slave
    always_comb begin
        dec_idx = N_SLV - 1;
        for (int k = NB - 1; k >= 0; k--) begin
            if (below[k]) dec_idx = k + 1;
        end
        if (!bus.cpu_addr[PERI_BIT]) dec_idx = 0;
        dec_sel = '0;
        for (int k = 0; k < N_SLV; k++) begin
            dec_sel[k] = (dec_idx == k);
        end
    end

    assign ready_hit = |(bus.slv_ready & sel_reg);

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (sel_reg[k]) sel_rdata = sel_rdata | bus.slv_rdata[k*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sel_next   = sel_reg;
        rd_next    = rd_reg;
        wr_next    = wr_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.cpu_rd && bus.cpu_wr) begin
                    // Contradictory request: report an error without touching any slave
                    state_next = S_ERR;
                    rdata_next = ERR_DATA;
                end else if (bus.cpu_rd || bus.cpu_wr) begin
                    state_next = S_ACCESS;
                    cnt_next   = '0;
                    sel_next   = dec_sel;
                    rd_next    = bus.cpu_rd;
                    wr_next    = bus.cpu_wr;
                    addr_next  = bus.cpu_addr;
                    wdata_next = bus.cpu_wdata;
                end
            end
            S_ACCESS: begin
                if (ready_hit) begin
                    if (rd_reg) rdata_next = sel_rdata;
                    sel_next   = '0;
                    rd_next    = 1'b0;
                    wr_next    = 1'b0;
                    state_next = S_DONE;
                end else begin
                    if (cnt_reg != T_MAX) cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_next == T_MAX) begin
                        if (rd_reg) rdata_next = ERR_DATA;
                        sel_next   = '0;
                        rd_next    = 1'b0;
                        wr_next    = 1'b0;
                        state_next = S_ERR;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            sel_reg   <= '0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            rd_reg    <= rd_next;
            wr_reg    <= wr_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
        end
    end

    // Stall is gated by reset so a request held during reset does not freeze the pipeline
    assign bus.cpu_stall = reset & (((state_reg == S_IDLE) & (bus.cpu_rd | bus.cpu_wr))
                                    | (state_reg == S_ACCESS));
    assign bus.cpu_err   = (state_reg == S_ERR);
    assign bus.cpu_rdata = rdata_reg;
    assign bus.slv_sel   = sel_reg;
    assign bus.slv_rd    = rd_reg;
    assign bus.slv_wr    = wr_reg;
    assign bus.slv_addr  = addr_reg;
    assign bus.slv_wdata = wdata_reg;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: a transaction-level model predicts every cycle's outputs,
// one negedge process compares them, and literal expectations pin the model.
module tb_mem_bus_ctrl;
    localparam int TIMEOUT = 15;
    localparam logic [31:0] ERR_DATA = 32'h0;
    localparam logic [31:0] D0 = 32'h12345678;
    localparam logic [31:0] D1 = 32'h71110001;
    localparam logic [31:0] D2 = 32'hCAFE0002;

    logic clk;
    logic reset;

    mem_bus_ctrl_if #(.DATA_W(32), .ADDR_W(32), .N_SLV(3)) bus ();

    mem_bus_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int stall_seen = 0;

    // Model state: what the outputs must show this cycle
    bit          e_valid = 1'b0;
    logic        e_stall, e_err, e_rd, e_wr;
    logic [2:0]  e_sel;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (e_valid) begin
            chk("cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
            chk("cpu_err",   32'(bus.cpu_err),   32'(e_err));
            chk("slv_sel",   32'(bus.slv_sel),   32'(e_sel));
            chk("slv_rd",    32'(bus.slv_rd),    32'(e_rd));
            chk("slv_wr",    32'(bus.slv_wr),    32'(e_wr));
            chk("slv_addr",  bus.slv_addr,       e_addr);
            chk("slv_wdata", bus.slv_wdata,      e_wdata);
            chk("cpu_rdata", bus.cpu_rdata,      e_rdata);
        end
    end

    function automatic logic [2:0] model_decode(input logic [31:0] a);
        if (!a[30])              return 3'b001;
        else if (a[7:0] < 8'h15) return 3'b010;
        else                     return 3'b100;
    endfunction

    function automatic logic [31:0] model_data(input logic [2:0] sel);
        case (sel)
            3'b001:  return D0;
            3'b010:  return D1;
            default: return D2;
        endcase
    endfunction

    // Publish this cycle's expectation, let the compare process run, then count stalls
    task automatic step(input logic st, input logic er, input logic [2:0] sl,
                        input logic r, input logic w);
        e_stall = st; e_err = er; e_sel = sl; e_rd = r; e_wr = w;
        e_addr = m_addr; e_wdata = m_wdata; e_rdata = m_rdata;
        e_valid = 1'b1;
        @(negedge clk);
        #1;
        if (bus.cpu_stall) stall_seen++;
    endtask

    // ready_at: ACCESS cycle (1-based) in which the selected slave answers; 0 = never
    task automatic run_txn(input string tag, input logic rd, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ready_at, input logic [2:0] lit_sel,
                           input int lit_stall, input logic [31:0] lit_rdata);
        logic [2:0] sel;
        bit ok;
        bit fin;
        stall_seen = 0;
        @(posedge clk); #1;
        bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        bus.slv_ready = '0;
        step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        if (rd && wr) begin
            @(posedge clk); #1;
            bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
            m_rdata = ERR_DATA;
            step(1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
            sel = 3'b000;
        end else begin
            sel = model_decode(addr);
            m_addr = addr;
            m_wdata = wdata;
            ok = 1'b0;
            fin = 1'b0;
            for (int i = 1; !fin; i++) begin
                @(posedge clk); #1;
                // Unselected slaves shout ready while the target is still waiting
                bus.slv_ready = (i == ready_at) ? sel : ~sel;
                step(1'b1, 1'b0, sel, rd, wr);
                if (i == 1) chk({tag, "_sel"}, 32'(bus.slv_sel), 32'(lit_sel));
                if (i == ready_at) begin ok = 1'b1; fin = 1'b1; end
                else if (i == TIMEOUT) fin = 1'b1;
            end
            @(posedge clk); #1;
            bus.slv_ready = '0;
            if (ok) begin
                if (rd) m_rdata = model_data(sel);
                step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
            end else begin
                if (rd) m_rdata = ERR_DATA;
                step(1'b0, 1'b1, 3'b000, 1'b0, 1'b0);
            end
        end
        @(posedge clk); #1;
        bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        chk({tag, "_stalls"}, 32'(stall_seen), 32'(lit_stall));
        chk({tag, "_rdata"}, bus.cpu_rdata, lit_rdata);
        $display("txn %s rd=%b wr=%b addr=%h sel=%b stalls=%0d rdata=%h",
                 tag, rd, wr, addr, sel, stall_seen, bus.cpu_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        bus.cpu_rd = 1'b1;
        bus.cpu_wr = 1'b0;
        bus.cpu_addr = 32'h0000_0010;
        bus.cpu_wdata = 32'h0;
        bus.slv_ready = '0;
        bus.slv_rdata = {D2, D1, D0};
        e_stall = 1'b0; e_err = 1'b0; e_sel = '0; e_rd = 1'b0; e_wr = 1'b0;
        e_addr = '0; e_wdata = '0; e_rdata = '0;
        e_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_stall", 32'(bus.cpu_stall), 32'h0);
        bus.cpu_rd = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);

        run_txn("dm_rd0",     1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1,  3'b001, 2,  32'h12345678);
        run_txn("tmr_wr",     1'b0, 1'b1, 32'h4000_0008, 32'hA5A5A5A5, 2,  3'b010, 3,  32'h12345678);
        run_txn("uart_rd3",   1'b1, 1'b0, 32'h4000_0018, 32'h0000_0000, 4,  3'b100, 5,  32'hCAFE0002);
        run_txn("bnd_lo",     1'b1, 1'b0, 32'h4000_0014, 32'h0000_1111, 1,  3'b010, 2,  32'h71110001);
        run_txn("bnd_hi",     1'b0, 1'b1, 32'h4000_0015, 32'h5555_AAAA, 1,  3'b100, 2,  32'h71110001);
        run_txn("rdy_at_to",  1'b1, 1'b0, 32'h0000_0020, 32'h0000_0000, 15, 3'b001, 16, 32'h12345678);
        run_txn("timeout",    1'b1, 1'b0, 32'h4000_0020, 32'h0000_0000, 0,  3'b100, 16, 32'h00000000);
        run_txn("illegal",    1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0,  3'b000, 1,  32'h00000000);
        run_txn("after_err",  1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1,  3'b001, 2,  32'h12345678);

        // Reset in the second ACCESS cycle of a UART read that never completes
        @(posedge clk); #1;
        bus.cpu_rd = 1'b1; bus.cpu_addr = 32'h4000_0030; bus.cpu_wdata = 32'h0BAD_F00D;
        step(1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
        @(posedge clk); #1;
        m_addr = 32'h4000_0030; m_wdata = 32'h0BAD_F00D;
        step(1'b1, 1'b0, 3'b100, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("mid_rst_pre_rd", 32'(bus.slv_rd), 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_rd",    32'(bus.slv_rd),    32'h0);
        chk("mid_rst_sel",   32'(bus.slv_sel),   32'h0);
        chk("mid_rst_stall", 32'(bus.cpu_stall), 32'h0);
        m_addr = '0; m_wdata = '0; m_rdata = '0;
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        @(posedge clk); #1;
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        bus.cpu_rd = 1'b0;
        reset = 1'b1;
        $display("txn mid_reset addr=%h stall=%b err=%b", 32'h4000_0030, bus.cpu_stall, bus.cpu_err);
        @(posedge clk); #1;
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
        run_txn("post_rst",   1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 1,  3'b001, 2,  32'h12345678);

        e_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
